// File: rtl/fp_class_if.sv
// Operand/result handshake bundle for the FP classify unit.
// The master drives operands and result-ready; the slave is the classifier.
interface fp_class_if;
  logic        fp_class_i_valid;
  logic        fp_class_o_ready;
  logic [63:0] fp_class_i_data;
  logic [1:0]  fp_class_i_fmt;
  logic        fp_class_o_valid;
  logic        fp_class_i_ready;
  logic [63:0] fp_class_o_result;

  modport master (
    output fp_class_i_valid, fp_class_i_data, fp_class_i_fmt, fp_class_i_ready,
    input  fp_class_o_ready, fp_class_o_valid, fp_class_o_result
  );

  modport slave (
    input  fp_class_i_valid, fp_class_i_data, fp_class_i_fmt, fp_class_i_ready,
    output fp_class_o_ready, fp_class_o_valid, fp_class_o_result
  );
endinterface

// File: rtl/fp_class.sv
// Two-stage FCLASS.S/FCLASS.D unit: stage 1 decodes the operand fields,
// stage 2 holds the RISC-V one-hot class mask for integer writeback.
module fp_class #(
  parameter bit NANBOX_CHECK = 1'b0
) (
  input  logic       fp_class_i_clk,
  input  logic       fp_class_i_rst_n,
  fp_class_if.slave  bus
);

  logic       s1_vld_reg;
  logic       s1_sign_reg;
  logic       s1_exp_zero_reg;
  logic       s1_exp_ones_reg;
  logic       s1_man_zero_reg;
  logic       s1_man_msb_reg;
  logic       s1_fmt_ok_reg;
  logic       s1_boxfail_reg;
  logic       s2_vld_reg;
  logic [9:0] s2_mask_reg;

  logic       s1_adv;
  logic       s2_adv;
  logic       in_xfer;
  logic       is_f64;
  logic       sign_next;
  logic       exp_zero_next;
  logic       exp_ones_next;
  logic       man_zero_next;
  logic       man_msb_next;
  logic       fmt_ok_next;
  logic       boxfail_next;
  logic [9:0] mask_next;

  // A stage may advance when it is empty or the stage after it is moving.
  assign s2_adv  = !s2_vld_reg || bus.fp_class_i_ready;
  assign s1_adv  = !s1_vld_reg || s2_adv;
  assign in_xfer = bus.fp_class_i_valid && s1_adv;

  assign bus.fp_class_o_ready  = s1_adv;
  assign bus.fp_class_o_valid  = s2_vld_reg;
  assign bus.fp_class_o_result = {54'd0, (s2_vld_reg ? s2_mask_reg : 10'd0)};

  assign is_f64        = (bus.fp_class_i_fmt == 2'd1);
  assign fmt_ok_next   = !bus.fp_class_i_fmt[1];
  assign boxfail_next  = NANBOX_CHECK && (bus.fp_class_i_fmt == 2'd0) &&
                         (bus.fp_class_i_data[63:32] != 32'hFFFF_FFFF);
  assign sign_next     = is_f64 ? bus.fp_class_i_data[63] : bus.fp_class_i_data[31];
  assign exp_zero_next = is_f64 ? (bus.fp_class_i_data[62:52] == 11'd0)
                                : (bus.fp_class_i_data[30:23] == 8'd0);
  assign exp_ones_next = is_f64 ? (&bus.fp_class_i_data[62:52])
                                : (&bus.fp_class_i_data[30:23]);
  assign man_zero_next = is_f64 ? (bus.fp_class_i_data[51:0] == 52'd0)
                                : (bus.fp_class_i_data[22:0] == 23'd0);
  assign man_msb_next  = is_f64 ? bus.fp_class_i_data[51] : bus.fp_class_i_data[22];

  always_comb begin
    mask_next = 10'd0;
    if (!s1_fmt_ok_reg) begin
      mask_next = 10'd0;
    end else if (s1_boxfail_reg) begin
      mask_next[9] = 1'b1;
    end else if (s1_exp_ones_reg) begin
      if (s1_man_zero_reg) begin
        mask_next[s1_sign_reg ? 0 : 7] = 1'b1;
      end else begin
        mask_next[s1_man_msb_reg ? 9 : 8] = 1'b1;
      end
    end else if (s1_exp_zero_reg) begin
      if (s1_man_zero_reg) begin
        mask_next[s1_sign_reg ? 3 : 4] = 1'b1;
      end else begin
        mask_next[s1_sign_reg ? 2 : 5] = 1'b1;
      end
    end else begin
      mask_next[s1_sign_reg ? 1 : 6] = 1'b1;
    end
  end

  always_ff @(posedge fp_class_i_clk) begin
    if (!fp_class_i_rst_n) begin
      s1_vld_reg  <= 1'b0;
      s2_vld_reg  <= 1'b0;
      s2_mask_reg <= 10'd0;
    end else begin
      if (s1_adv) begin
        s1_vld_reg <= bus.fp_class_i_valid;
      end
      if (s2_adv) begin
        s2_vld_reg <= s1_vld_reg;
        if (s1_vld_reg) begin
          s2_mask_reg <= mask_next;
        end
      end
    end
  end

  // Decode fields carry no reset; their valid bit alone qualifies them.
  always_ff @(posedge fp_class_i_clk) begin
    if (in_xfer) begin
      s1_sign_reg     <= sign_next;
      s1_exp_zero_reg <= exp_zero_next;
      s1_exp_ones_reg <= exp_ones_next;
      s1_man_zero_reg <= man_zero_next;
      s1_man_msb_reg  <= man_msb_next;
      s1_fmt_ok_reg   <= fmt_ok_next;
      s1_boxfail_reg  <= boxfail_next;
    end
  end

endmodule

// File: tb/tb_fp_class.sv
// Directed and randomized bench for fp_class: one step per clock, a class
// scoreboard for every result, and hand-computed values at the directed points.
module tb_fp_class;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_class_if bus ();
  fp_class_if nbus ();

  fp_class #(.NANBOX_CHECK(1'b0)) dut (
    .fp_class_i_clk   (clk),
    .fp_class_i_rst_n (rst_n),
    .bus              (bus)
  );

  fp_class #(.NANBOX_CHECK(1'b1)) dut_nb (
    .fp_class_i_clk   (clk),
    .fp_class_i_rst_n (rst_n),
    .bus              (nbus)
  );

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  logic [9:0]  sb_q[$];
  logic        last_ready;
  logic        last_valid;
  logic [63:0] last_result;
  logic [63:0] vec_d[0:5];
  logic [9:0]  vec_e[0:5];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] golden(input logic [63:0] d, input logic [1:0] f, input bit nb);
    logic        s;
    int unsigned e;
    int unsigned emax;
    logic [51:0] m;
    logic        mtop;
    if (f[1]) return 10'h000;
    if (nb && f == 2'd0 && d[63:32] != 32'hFFFF_FFFF) return 10'h200;
    if (f == 2'd0) begin
      s = d[31]; e = d[30:23]; emax = 255; m = {29'd0, d[22:0]}; mtop = d[22];
    end else begin
      s = d[63]; e = d[62:52]; emax = 2047; m = d[51:0]; mtop = d[51];
    end
    if (e == emax) return (m == 0) ? (s ? 10'h001 : 10'h080) : (mtop ? 10'h200 : 10'h100);
    if (e == 0)    return (m == 0) ? (s ? 10'h008 : 10'h010) : (s ? 10'h004 : 10'h020);
    return s ? 10'h002 : 10'h040;
  endfunction

  // One clock: drive at the falling edge, sample 1ns later, score the handshakes.
  task automatic step(input bit v, input logic [63:0] d, input logic [1:0] f, input bit r);
    @(negedge clk);
    bus.fp_class_i_valid = v;
    bus.fp_class_i_data  = d;
    bus.fp_class_i_fmt   = f;
    bus.fp_class_i_ready = r;
    #1;
    last_ready  = bus.fp_class_o_ready;
    last_valid  = bus.fp_class_o_valid;
    last_result = bus.fp_class_o_result;
    if (last_valid && r) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", {63'd0, last_valid}, 64'd0);
      end else begin
        check("sb_result", last_result, {54'd0, sb_q[0]});
        void'(sb_q.pop_front());
      end
      out_cnt++;
    end
    if (v && last_ready) begin
      sb_q.push_back(golden(d, f, 1'b0));
      acc_cnt++;
    end
  endtask

  task automatic run_stream(input logic [1:0] f, input string tag);
    for (int k = 0; k < 8; k++) begin
      step(k < 6, (k < 6) ? vec_d[k] : 64'd0, f, 1'b1);
      if (k >= 2) begin
        check({tag, "_valid"}, {63'd0, last_valid}, 64'd1);
        check({tag, "_result"}, last_result, {54'd0, vec_e[k-2]});
      end
    end
  endtask

  initial begin
    logic [63:0] rd;
    bus.fp_class_i_valid  = 1'b0;
    bus.fp_class_i_data   = 64'd0;
    bus.fp_class_i_fmt    = 2'd0;
    bus.fp_class_i_ready  = 1'b1;
    nbus.fp_class_i_valid = 1'b0;
    nbus.fp_class_i_data  = 64'd0;
    nbus.fp_class_i_fmt   = 2'd0;
    nbus.fp_class_i_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_valid", {63'd0, bus.fp_class_o_valid}, 64'd0);
    check("rst_result", bus.fp_class_o_result, 64'd0);
    check("rst_ready", {63'd0, bus.fp_class_o_ready}, 64'd1);

    // F32 stream, upper bits zero
    vec_d[0] = 64'h0000_0000_ff80_0000; vec_e[0] = 10'h001;
    vec_d[1] = 64'h0000_0000_0000_0000; vec_e[1] = 10'h010;
    vec_d[2] = 64'h0000_0000_8000_0001; vec_e[2] = 10'h004;
    vec_d[3] = 64'h0000_0000_3f80_0000; vec_e[3] = 10'h040;
    vec_d[4] = 64'h0000_0000_7f80_0001; vec_e[4] = 10'h100;
    vec_d[5] = 64'h0000_0000_7fc0_0001; vec_e[5] = 10'h200;
    run_stream(2'd0, "f32");

    // F64 stream
    vec_d[0] = 64'h8000_0000_0000_0000; vec_e[0] = 10'h008;
    vec_d[1] = 64'hbff0_0000_0000_0000; vec_e[1] = 10'h002;
    vec_d[2] = 64'h7ff0_0000_0000_0000; vec_e[2] = 10'h080;
    vec_d[3] = 64'h0000_0000_0000_0001; vec_e[3] = 10'h020;
    vec_d[4] = 64'h7ff0_0000_0000_0001; vec_e[4] = 10'h100;
    vec_d[5] = 64'h7ff8_0000_0000_0001; vec_e[5] = 10'h200;
    run_stream(2'd1, "f64");

    // Backpressure: two accepted, then stall with a third operand offered
    step(1'b1, 64'h3f80_0000, 2'd0, 1'b0);
    check("bp_ready0", {63'd0, last_ready}, 64'd1);
    step(1'b1, 64'hff80_0000, 2'd0, 1'b0);
    check("bp_ready1", {63'd0, last_ready}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 64'h0, 2'd0, 1'b0);
      check("bp_stall_ready", {63'd0, last_ready}, 64'd0);
      check("bp_stall_valid", {63'd0, last_valid}, 64'd1);
      check("bp_stall_result", last_result, 64'h040);
    end
    step(1'b1, 64'h0, 2'd0, 1'b1);
    check("bp_out0", last_result, 64'h040);
    step(1'b1, 64'h7fc0_0000, 2'd0, 1'b1);
    check("bp_out1", last_result, 64'h001);
    step(1'b0, 64'h0, 2'd0, 1'b1);
    check("bp_out2", last_result, 64'h010);
    step(1'b0, 64'h0, 2'd0, 1'b1);
    check("bp_out3", last_result, 64'h200);
    step(1'b0, 64'h0, 2'd0, 1'b1);
    check("bp_drained", {63'd0, last_valid}, 64'd0);

    // Unsupported formats
    rd = {$urandom, $urandom};
    step(1'b1, rd, 2'd2, 1'b1);
    rd = {$urandom, $urandom};
    step(1'b1, rd, 2'd3, 1'b1);
    step(1'b0, 64'h0, 2'd0, 1'b1);
    check("fmt2_valid", {63'd0, last_valid}, 64'd1);
    check("fmt2_result", last_result, 64'd0);
    step(1'b0, 64'h0, 2'd0, 1'b1);
    check("fmt3_valid", {63'd0, last_valid}, 64'd1);
    check("fmt3_result", last_result, 64'd0);
    step(1'b0, 64'h0, 2'd0, 1'b1);

    // NaN-boxing on the checking instance
    @(negedge clk);
    nbus.fp_class_i_valid = 1'b1;
    nbus.fp_class_i_fmt   = 2'd0;
    nbus.fp_class_i_data  = 64'h0000_0000_3f80_0000;
    @(negedge clk);
    nbus.fp_class_i_data  = 64'hFFFF_FFFF_3f80_0000;
    @(negedge clk);
    nbus.fp_class_i_valid = 1'b0;
    #1;
    check("nanbox_fail", nbus.fp_class_o_result, 64'h200);
    @(negedge clk);
    #1;
    check("nanbox_ok", nbus.fp_class_o_result, 64'h040);

    // Reset with two operands in flight
    step(1'b1, 64'h3f80_0000, 2'd0, 1'b0);
    step(1'b1, 64'h0000_0001, 2'd0, 1'b0);
    @(negedge clk);
    bus.fp_class_i_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_valid", {63'd0, bus.fp_class_o_valid}, 64'd0);
    check("mrst_result", bus.fp_class_o_result, 64'd0);
    check("mrst_ready", {63'd0, bus.fp_class_o_ready}, 64'd1);
    sb_q.delete();
    acc_cnt = 0;
    out_cnt = 0;
    for (int k = 0; k < 4; k++) step(1'b0, 64'h0, 2'd0, 1'b1);

    // Random operands with random handshakes
    for (int k = 0; k < 1000; k++) begin
      logic [1:0] f;
      rd = {$urandom, $urandom};
      f  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin rd[30:23] = 8'hFF; rd[62:52] = 11'h7FF; end
        1: begin rd[30:23] = 8'h00; rd[62:52] = 11'h000; end
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        rd[22:0] = 23'd0; rd[51:0] = 52'd0;
      end
      step($urandom_range(0, 3) != 0, rd, f, $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 64'h0, 2'd0, 1'b1);
    check("rand_count", 64'(out_cnt), 64'(acc_cnt));
    check("rand_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
